// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch with prefetch FIFO, credit-based requests and
//            redirect flush of buffered and in-flight instructions.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW:0] c_DEPTH_W = DEPTH[c_CW:0];

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_fetch_pc;
  logic [31:0]       r_rsp_pc;
  logic [c_CW-1:0]   r_outstanding;
  logic [c_CW-1:0]   r_count;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW-1:0]   r_wr_ptr;
  logic [31:0]       r_mem_pc   [DEPTH];
  logic [31:0]       r_mem_data [DEPTH];

  logic [c_CW:0]     w_credit_sum;
  logic              w_req_fire;
  logic              w_rsp_take;
  logic              w_redirect;
  logic              w_push;
  logic              w_pop;
  logic [c_CW-1:0]   w_outstanding_nxt;
  logic [31:0]       w_redirect_pc;
  logic              w_unused;

  // Requests are gated purely by registered state so memory sees a clean valid.
  assign w_credit_sum   = {1'b0, r_count} + {1'b0, r_outstanding};
  assign imem_req_valid = (r_state == S_RUN) && (w_credit_sum < c_DEPTH_W);
  assign imem_req_addr  = r_fetch_pc;

  assign w_req_fire    = imem_req_valid && imem_req_ready;
  assign w_rsp_take    = imem_rsp_valid && (r_outstanding != '0);
  assign w_redirect    = redirect_valid && (r_state != S_RESET);
  assign w_push        = w_rsp_take && (r_state == S_RUN) && !w_redirect;
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_unused      = ^redirect_pc[1:0];

  assign instr_valid = (r_count != '0) && (r_state != S_FLUSH);
  assign instr_data  = r_mem_data[r_rd_ptr];
  assign instr_pc    = r_mem_pc[r_rd_ptr];
  assign w_pop       = instr_valid && instr_ready;

  assign w_outstanding_nxt = r_outstanding
                           + {{(c_CW-1){1'b0}}, w_req_fire}
                           - {{(c_CW-1){1'b0}}, w_rsp_take};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RESET: w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_redirect && (w_outstanding_nxt != '0))
          w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (w_outstanding_nxt == '0)
          w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_RESET;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]   <= '0;
        r_mem_data[i] <= '0;
      end
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_outstanding_nxt;

      if (w_redirect)
        r_fetch_pc <= w_redirect_pc;
      else if (w_req_fire)
        r_fetch_pc <= r_fetch_pc + 32'd4;

      if (w_redirect)
        r_rsp_pc <= w_redirect_pc;
      else if (w_push)
        r_rsp_pc <= r_rsp_pc + 32'd4;

      // A redirect empties the queue even if the decoder pops this cycle.
      if (w_redirect) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) begin
          r_mem_pc[r_wr_ptr]   <= r_rsp_pc;
          r_mem_data[r_wr_ptr] <= imem_rsp_data;
          r_wr_ptr             <= r_wr_ptr + 1'b1;
        end
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count
                 + {{(c_CW-1){1'b0}}, w_push}
                 - {{(c_CW-1){1'b0}}, w_pop};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Scoreboard bench for fetch_unit with an in-order latency memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] ep;
    logic [31:0] due;
  } pend_t;

  int          errors = 0;
  int          checks = 0;
  pend_t       pend_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_fetch = RESET_PC;
  int unsigned epoch     = 0;
  int unsigned cyc       = 0;
  int unsigned mem_lat   = 1;
  int unsigned n_accepts = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Memory: answers the oldest request once its latency has elapsed.
  always @(posedge clk) begin
    #1;
    if (rst && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  // Each negedge observes the handshakes that the coming posedge will commit.
  always @(negedge clk) begin
    pend_t       p;
    logic [63:0] e;
    if (!rst) begin
      pend_q.delete();
      exp_q.delete();
      exp_fetch = RESET_PC;
      epoch++;
      n_accepts = 0;
    end else begin
      if (instr_valid && instr_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_instr: got pc=%h data=%h, required nothing (no expected entry)", instr_pc, instr_data);
        end else begin
          e = exp_q.pop_front();
          if ({instr_pc, instr_data} !== e) begin
            errors++;
            $display("FAIL sb_instr: got pc=%h data=%h, required pc=%h data=%h", instr_pc, instr_data, e[63:32], e[31:0]);
          end
        end
      end
      if (imem_rsp_valid && pend_q.size() > 0) begin
        p = pend_q.pop_front();
        if (p.ep == epoch && !redirect_valid)
          exp_q.push_back({p.addr, mem_word(p.addr)});
      end
      if (imem_req_valid && imem_req_ready) begin
        checks++;
        if (imem_req_addr !== exp_fetch) begin
          errors++;
          $display("FAIL sb_req_addr: got %h, required %h", imem_req_addr, exp_fetch);
        end
        pend_q.push_back('{addr: imem_req_addr, ep: epoch, due: cyc + mem_lat});
        exp_fetch = exp_fetch + 32'd4;
        n_accepts++;
      end
      if (redirect_valid) begin
        epoch++;
        exp_fetch = {redirect_pc[31:2], 2'b00};
        exp_q.delete();
      end
    end
    cyc++;
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic apply_redirect(input logic [31:0] pc);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  task automatic wait_first_pop(input string name, input logic [31:0] want_pc);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        found = 1;
        checks++;
        if (instr_pc !== want_pc || instr_data !== mem_word(want_pc)) begin
          errors++;
          $display("FAIL %s: got pc=%h data=%h, required pc=%h data=%h", name, instr_pc, instr_data, want_pc, mem_word(want_pc));
        end
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL %s: got no instruction within 60 cycles, required pc=%h", name, want_pc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0; mem_lat = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b, required 0", imem_req_valid); end
    checks++; if (imem_req_addr !== RESET_PC) begin errors++; $display("FAIL rst_req_addr: got %h, required %h", imem_req_addr, RESET_PC); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid: got %b, required 0", instr_valid); end
    checks++; if (instr_data !== 32'h0) begin errors++; $display("FAIL rst_instr_data: got %h, required 0", instr_data); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc: got %h, required 0", instr_pc); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL startup_idle: got req_valid=%b, required 0", imem_req_valid); end
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin errors++; $display("FAIL startup_req: got valid=%b addr=%h, required 1 %h", imem_req_valid, imem_req_addr, RESET_PC); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL startup_early: got instr_valid=%b, required 0", instr_valid); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== RESET_PC) begin errors++; $display("FAIL startup_first: got valid=%b pc=%h, required 1 %h", instr_valid, instr_pc, RESET_PC); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL startup_stream: got instr_valid=%b in cycle %0d, required 1", instr_valid, i); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pcs [4];
    int          n = 0;
    @(posedge clk); #1 instr_ready = 1'b0; mem_lat = 1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        checks++;
        if (instr_pc !== RESET_PC || instr_data !== mem_word(RESET_PC)) begin errors++; $display("FAIL bp_hold: got pc=%h data=%h, required %h %h", instr_pc, instr_data, RESET_PC, mem_word(RESET_PC)); end
      end
    end
    checks++; if (n_accepts != 4) begin errors++; $display("FAIL bp_requests: got %0d, required 4", n_accepts); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_stall: got %b, required 0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b, required 1", instr_valid); end
    @(posedge clk); #1 instr_ready = 1'b1;
    for (int i = 0; i < 30 && n < 4; i++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin pcs[n] = instr_pc; n++; end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= n || pcs[k] !== RESET_PC + 32'(4 * k)) begin
        errors++;
        $display("FAIL bp_drain%0d: got %h (popped %0d), required %h", k, (k < n) ? pcs[k] : 32'hx, n, RESET_PC + 32'(4 * k));
      end
    end
  endtask

  task automatic test_async_reset();
    repeat (5) @(posedge clk);
    @(negedge clk); #2 rst = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC) begin errors++; $display("FAIL arst_req: got valid=%b addr=%h, required 0 %h", imem_req_valid, imem_req_addr, RESET_PC); end
    checks++; if (instr_valid !== 1'b0 || instr_data !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL arst_instr: got valid=%b data=%h pc=%h, required 0 0 0", instr_valid, instr_data, instr_pc); end
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    wait_first_pop("arst_restart", RESET_PC);
  endtask

  task automatic test_redirect_inflight();
    @(posedge clk); #1 mem_lat = 3;
    repeat (10) @(posedge clk);
    apply_redirect(32'h0000_0100);
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL flush_quiet: got instr_valid=%b req_valid=%b, required 0 0", instr_valid, imem_req_valid); end
    wait_first_pop("flush_first", 32'h0000_0100);
  endtask

  task automatic test_redirect_collision();
    @(posedge clk); #1 mem_lat = 1;
    repeat (8) @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_rsp_valid !== 1'b1) begin errors++; $display("FAIL coll_setup: got req_valid=%b rsp_valid=%b, required 1 1", imem_req_valid, imem_rsp_valid); end
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL coll_flush: got instr_valid=%b req_valid=%b, required 0 0", instr_valid, imem_req_valid); end
    wait_first_pop("coll_first", 32'h0000_0200);
  endtask

  task automatic test_wrap();
    logic [31:0] pcs [3];
    logic [31:0] want [3];
    int          n = 0;
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
    repeat (4) @(posedge clk);
    apply_redirect(32'hFFFF_FFF8);
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin pcs[n] = instr_pc; n++; end
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (k >= n || pcs[k] !== want[k]) begin
        errors++;
        $display("FAIL wrap%0d: got %h (popped %0d), required %h", k, (k < n) ? pcs[k] : 32'hx, n, want[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_async_reset();
    test_redirect_inflight();
    test_redirect_collision();
    test_wrap();
    repeat (10) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
